// File: rtl/seg_scan_sched.sv
// seg_scan_sched: shares the 8-digit seven-segment display between the
// mm:ss game timer (left four digits) and the BCD step counter (right
// three digits). A sequential double-dabble converter turns the binary
// step count into BCD; the timer runs from a TICK_DIV prescaler; digits
// are scanned one at a time with a SCAN_DIV dwell.
//
// Optional feature macro: SEG_BLINK_ON_WIN_EN -- when defined, the whole
// display blinks (digit enables forced off every other prescaler period)
// while game_status is WINNED.
//
// Handshakes: none. step_number is a level input; any value that differs
// from the last converted value is picked up when the converter is idle,
// so the displayed count always converges to the latest input.
module seg_scan_sched #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [1:0]  game_status,
    input  logic [7:0]  step_number,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic [15:0] time_bcd,
    output logic [11:0] step_bcd
);

    localparam logic [1:0] ST_CHOSE_BOARD  = 2'b00;
    localparam logic [1:0] ST_GAMING       = 2'b01;
    localparam logic [1:0] ST_GAME_INITIAL = 2'b10;
    localparam logic [1:0] ST_WINNED       = 2'b11;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    logic [26:0]  r_presc;
    logic [15:0]  r_time;
    logic [19:0]  r_scan;
    logic [2:0]   r_dig;
    logic [7:0]   r_seg_en;
    logic [7:0]   r_seg_out;
    conv_state_t  r_conv_state;
    logic [7:0]   r_src;
    logic [19:0]  r_dd;
    logic [2:0]   r_bit_cnt;
    logic [11:0]  r_step_bcd;

    logic         w_presc_wrap;
    logic         w_scan_wrap;
    logic         w_blink_mask;
    logic [15:0]  w_time_next;
    logic [19:0]  w_dd_adj;
    logic [3:0]   w_nib;
    logic         w_blank;
    logic         w_dp;
    logic [7:0]   w_seg;

    assign w_presc_wrap = (r_presc == 27'(TICK_DIV - 1));
    assign w_scan_wrap  = (r_scan == 20'(SCAN_DIV - 1));

    assign seg_en   = r_seg_en;
    assign seg_out  = r_seg_out;
    assign time_bcd = r_time;
    assign step_bcd = r_step_bcd;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 8'h3F;
            4'd1:    seg_decode = 8'h06;
            4'd2:    seg_decode = 8'h5B;
            4'd3:    seg_decode = 8'h4F;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'h6D;
            4'd6:    seg_decode = 8'h7D;
            4'd7:    seg_decode = 8'h07;
            4'd8:    seg_decode = 8'h7F;
            4'd9:    seg_decode = 8'h6F;
            default: seg_decode = 8'h00;
        endcase
    endfunction

    // Next mm:ss value with BCD carries (caller guards the 59:59 saturation)
    always_comb begin
        w_time_next = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_time_next[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_next[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
                w_time_next[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_next[7:4] = 4'd0;
                if (r_time[11:8] != 4'd9) begin
                    w_time_next[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_next[11:8]  = 4'd0;
                    w_time_next[15:12] = r_time[15:12] + 4'd1;
                end
            end
        end
    end

    // Prescaler and game timer; only a tick sampled while GAMING advances time
    always_ff @(posedge clk_d) begin
        if (!rst) begin
            r_presc <= '0;
            r_time  <= '0;
        end else begin
            case (game_status)
                ST_GAMING: begin
                    r_presc <= w_presc_wrap ? 27'd0 : r_presc + 27'd1;
                    if (w_presc_wrap && (r_time != 16'h5959)) begin
                        r_time <= w_time_next;
                    end
                end
                ST_WINNED: begin
                    r_presc <= w_presc_wrap ? 27'd0 : r_presc + 27'd1;
                end
                default: begin
                    r_presc <= '0;
                    r_time  <= '0;
                end
            endcase
        end
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        w_dd_adj = r_dd;
        for (int n = 0; n < 3; n++) begin
            if (r_dd[8 + 4*n +: 4] >= 4'd5) begin
                w_dd_adj[8 + 4*n +: 4] = r_dd[8 + 4*n +: 4] + 4'd3;
            end
        end
    end

    // Step converter FSM: capture, eight shift iterations, then publish
    always_ff @(posedge clk_d) begin
        if (!rst) begin
            r_conv_state <= CONV_IDLE;
            r_src        <= '0;
            r_dd         <= '0;
            r_bit_cnt    <= '0;
            r_step_bcd   <= '0;
        end else begin
            case (r_conv_state)
                CONV_IDLE: begin
                    if (step_number != r_src) begin
                        r_src        <= step_number;
                        r_dd         <= {12'h000, step_number};
                        r_bit_cnt    <= 3'd0;
                        r_conv_state <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    r_dd      <= {w_dd_adj[18:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_conv_state <= CONV_DONE;
                    end
                end
                CONV_DONE: begin
                    r_step_bcd   <= r_dd[19:8];
                    r_conv_state <= CONV_IDLE;
                end
                default: r_conv_state <= CONV_IDLE;
            endcase
        end
    end

`ifdef SEG_BLINK_ON_WIN_EN
    logic r_blink;

    // Blink phase: held clear outside WINNED, toggles each prescaler wrap inside it
    always_ff @(posedge clk_d) begin
        if (!rst) begin
            r_blink <= 1'b0;
        end else if (game_status != ST_WINNED) begin
            r_blink <= 1'b0;
        end else if (w_presc_wrap) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_blink_mask = r_blink;
`else
    assign w_blink_mask = 1'b0;
`endif

    // Digit map: timer on the left with a dp separator, step count on the right
    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        w_dp    = 1'b0;
        case (r_dig)
            3'd7: w_nib = r_time[15:12];
            3'd6: begin
                w_nib = r_time[11:8];
                w_dp  = 1'b1;
            end
            3'd5: w_nib = r_time[7:4];
            3'd4: w_nib = r_time[3:0];
            3'd3: w_blank = 1'b1;
            3'd2: begin
                w_nib   = r_step_bcd[11:8];
                w_blank = (r_step_bcd[11:8] == 4'd0);
            end
            3'd1: begin
                w_nib   = r_step_bcd[7:4];
                w_blank = (r_step_bcd[11:8] == 4'd0) && (r_step_bcd[7:4] == 4'd0);
            end
            default: w_nib = r_step_bcd[3:0];
        endcase
        w_seg = (w_blank ? 8'h00 : seg_decode(w_nib)) | (w_dp ? 8'h80 : 8'h00);
    end

    // Scan counter, digit index and registered segment/enable outputs
    always_ff @(posedge clk_d) begin
        if (!rst) begin
            r_scan    <= '0;
            r_dig     <= '0;
            r_seg_en  <= '0;
            r_seg_out <= '0;
        end else begin
            if (w_scan_wrap) begin
                r_scan <= '0;
                r_dig  <= r_dig + 3'd1;
            end else begin
                r_scan <= r_scan + 20'd1;
            end
            if (game_status == ST_CHOSE_BOARD) begin
                r_seg_en  <= 8'h00;
                r_seg_out <= 8'h00;
            end else begin
                r_seg_en  <= w_blink_mask ? 8'h00 : (8'h01 << r_dig);
                r_seg_out <= w_seg;
            end
        end
    end

    // GAME_INITIAL behaves like the default branch of the timer (held at zero)
    logic w_unused_initial;
    assign w_unused_initial = (game_status == ST_GAME_INITIAL);

endmodule

// File: tb/tb_seg_scan_sched.sv
// Bench for seg_scan_sched with TICK_DIV=4 and SCAN_DIV=2: reset, timer
// counting and saturation, scan walk and digit map, leading-zero blanking,
// converter restart on a mid-conversion change, tick vs WINNED entry, and
// the WINNED display (blinking when SEG_BLINK_ON_WIN_EN is defined).
`timescale 1ns/1ps
module tb_seg_scan_sched;

    localparam int TICK = 4;
    localparam int SCAN = 2;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [1:0]  game_status;
    logic [7:0]  step_number;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic [15:0] time_bcd;
    logic [11:0] step_bcd;

    int total = 0;
    int bad   = 0;
    int edge_k = 0;

    logic [11:0] exp_step_q[$];
    logic [15:0] exp_time_q[$];
    logic [15:0] exp_scan_q[$];
    logic [23:0] exp_lz_q[$];
    logic [7:0]  exp_en_q[$];

    seg_scan_sched #(
        .TICK_DIV(TICK),
        .SCAN_DIV(SCAN)
    ) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .game_status (game_status),
        .step_number (step_number),
        .seg_en      (seg_en),
        .seg_out     (seg_out),
        .time_bcd    (time_bcd),
        .step_bcd    (step_bcd)
    );

    // clock and edge count since reset release
    always #5 clk_d = ~clk_d;

    always @(posedge clk_d) begin
        edge_k <= rst ? edge_k + 1 : 0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_d);
            #1;
        end
    endtask

    // expected segments for time 59:59, step 037
    function automatic logic [7:0] map_5959_037(input int d);
        case (d)
            7:       map_5959_037 = 8'h6D;
            6:       map_5959_037 = 8'hEF;
            5:       map_5959_037 = 8'h6D;
            4:       map_5959_037 = 8'h6F;
            3:       map_5959_037 = 8'h00;
            2:       map_5959_037 = 8'h00;
            1:       map_5959_037 = 8'h4F;
            default: map_5959_037 = 8'h07;
        endcase
    endfunction

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b0;
        game_status = 2'b00;
        step_number = 8'd37;
        tick(3);
        total++; if (seg_en !== 8'h00) begin bad++; $display("FAIL rst_seg_en got=%h exp=00", seg_en); end
        total++; if (seg_out !== 8'h00) begin bad++; $display("FAIL rst_seg_out got=%h exp=00", seg_out); end
        total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL rst_time got=%h exp=0000", time_bcd); end
        total++; if (step_bcd !== 12'h000) begin bad++; $display("FAIL rst_step got=%h exp=000", step_bcd); end
        rst = 1'b1;
        exp_step_q.push_back(12'h037);
        tick(9);
        total++; if (step_bcd !== 12'h000) begin bad++; $display("FAIL step_early got=%h exp=000", step_bcd); end
        tick(1);
        e = exp_step_q.pop_front();
        total++; if (step_bcd !== e) begin bad++; $display("FAIL step_latency got=%h exp=%h", step_bcd, e); end
    endtask

    task automatic test_timer();
        logic [15:0] e;
        game_status = 2'b01;
        exp_time_q.push_back(16'h0101);
        tick(TICK * 61);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL time_61s got=%h exp=%h", time_bcd, e); end
        exp_time_q.push_back(16'h5958);
        tick(TICK * (3598 - 61));
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL time_5958 got=%h exp=%h", time_bcd, e); end
        exp_time_q.push_back(16'h5959);
        tick(TICK);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL time_5959 got=%h exp=%h", time_bcd, e); end
        exp_time_q.push_back(16'h5959);
        tick(TICK * 2);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL time_sat got=%h exp=%h", time_bcd, e); end
    endtask

    task automatic test_scan_map();
        for (int i = 0; i < 16; i++) begin
            int d;
            logic [15:0] e;
            d = (edge_k / SCAN) % 8;
            exp_scan_q.push_back({8'd1 << d, map_5959_037(d)});
            tick(1);
            e = exp_scan_q.pop_front();
            total++; if (seg_en !== e[15:8]) begin bad++; $display("FAIL scan_en got=%h exp=%h", seg_en, e[15:8]); end
            total++; if (seg_out !== e[7:0]) begin bad++; $display("FAIL scan_seg got=%h exp=%h", seg_out, e[7:0]); end
        end
    endtask

    task automatic test_game_initial_clear();
        logic [15:0] e;
        game_status = 2'b10;
        exp_time_q.push_back(16'h0000);
        tick(1);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL init_clear got=%h exp=%h", time_bcd, e); end
    endtask

    task automatic test_chose_board();
        game_status = 2'b00;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] e;
            exp_scan_q.push_back(16'h0000);
            tick(1);
            e = exp_scan_q.pop_front();
            total++; if ({seg_en, seg_out} !== e) begin bad++; $display("FAIL chose_dark got=%h exp=%h", {seg_en, seg_out}, e); end
        end
    endtask

    task automatic test_leading_zero();
        game_status = 2'b10;
        for (int v = 0; v < 3; v++) begin
            logic [7:0]  h, t, o;
            logic [11:0] es;
            logic [23:0] el;
            case (v)
                0: begin step_number = 8'd7;   exp_step_q.push_back(12'h007); exp_lz_q.push_back(24'h000007); end
                1: begin step_number = 8'd105; exp_step_q.push_back(12'h105); exp_lz_q.push_back(24'h063F6D); end
                default: begin step_number = 8'd255; exp_step_q.push_back(12'h255); exp_lz_q.push_back(24'h5B6D6D); end
            endcase
            tick(12);
            es = exp_step_q.pop_front();
            total++; if (step_bcd !== es) begin bad++; $display("FAIL lz_step got=%h exp=%h", step_bcd, es); end
            h = 8'hFF; t = 8'hFF; o = 8'hFF;
            for (int i = 0; i < 16; i++) begin
                tick(1);
                if (seg_en == 8'h04) h = seg_out;
                if (seg_en == 8'h02) t = seg_out;
                if (seg_en == 8'h01) o = seg_out;
            end
            el = exp_lz_q.pop_front();
            total++; if ({h, t, o} !== el) begin bad++; $display("FAIL lz_digits got=%h exp=%h", {h, t, o}, el); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        step_number = 8'd3;
        exp_step_q.push_back(12'h003);
        exp_step_q.push_back(12'h004);
        tick(2);
        step_number = 8'd4;
        tick(8);
        e = exp_step_q.pop_front();
        total++; if (step_bcd !== e) begin bad++; $display("FAIL b2b_first got=%h exp=%h", step_bcd, e); end
        tick(9);
        total++; if (step_bcd !== 12'h003) begin bad++; $display("FAIL b2b_hold got=%h exp=003", step_bcd); end
        tick(1);
        e = exp_step_q.pop_front();
        total++; if (step_bcd !== e) begin bad++; $display("FAIL b2b_second got=%h exp=%h", step_bcd, e); end
    endtask

    task automatic test_tick_on_win();
        logic [15:0] e;
        game_status = 2'b01;
        exp_time_q.push_back(16'h0002);
        tick(TICK * 2 + 3);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL win_pre got=%h exp=%h", time_bcd, e); end
        game_status = 2'b11;
        exp_time_q.push_back(16'h0002);
        tick(1);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL win_tick_edge got=%h exp=%h", time_bcd, e); end
        exp_time_q.push_back(16'h0002);
        tick(8);
        e = exp_time_q.pop_front();
        total++; if (time_bcd !== e) begin bad++; $display("FAIL win_frozen got=%h exp=%h", time_bcd, e); end
    endtask

    task automatic test_win_display();
`ifdef SEG_BLINK_ON_WIN_EN
        logic z [24];
        for (int i = 0; i < 24; i++) begin
            tick(1);
            z[i] = (seg_en == 8'h00);
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (z[i] === z[i + 4]) begin
                bad++;
                $display("FAIL blink_phase idx=%0d got=%b exp=%b", i, z[i + 4], ~z[i]);
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            int d;
            logic [7:0] e;
            d = (edge_k / SCAN) % 8;
            exp_en_q.push_back(8'd1 << d);
            tick(1);
            e = exp_en_q.pop_front();
            total++; if (seg_en !== e) begin bad++; $display("FAIL win_steady got=%h exp=%h", seg_en, e); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_timer();
        test_scan_map();
        test_game_initial_clear();
        test_chose_board();
        test_leading_zero();
        test_back_to_back();
        test_tick_on_win();
        test_win_display();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_sched.md
# seg_scan_sched

Display scheduler that shares the board's 8-digit seven-segment display between the elapsed-game timer and the step counter. It sits beside `fsm` in `gameControl`, consuming `game_status` and `step_number`. Internally it:
- runs the mm:ss game timer;
- converts the binary step count to BCD with a sequential converter;
- time-multiplexes the digit enables.

## Interface
- `TICK_DIV`, default 100_000_000: `clk_d` cycles per timer second (2 ≤ value < 2^27).
- `SCAN_DIV`, default 100_000: `clk_d` cycles each digit stays enabled (2 ≤ value < 2^20).
- `clk_d`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `game_status`  in  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- `step_number`  in  8  binary step count, 0–255.
- `seg_en`  out  8  digit enables, active-high, one-hot or zero; bit 7 is the leftmost digit.
- `seg_out`  out  8  segments, active-high: bit0=a … bit6=g, bit7=dp.
- `time_bcd`  out  16  {m_hi, m_lo, s_hi, s_lo}, 4-bit BCD each.
- `step_bcd`  out  12  {hundreds, tens, ones}, BCD.

## Operation
- **Reset** (`rst`=0 at an edge) clears all registers:
  - `seg_en`=8'h00, `seg_out`=8'h00, `time_bcd`=16'h0000, `step_bcd`=12'h000;
  - prescaler=0, scan counter=0, digit index=0;
  - converter state IDLE, step source register=0.
- **Timer behaviour by state:**
  - CHOSE_BOARD or GAME_INITIAL: `time_bcd` and prescaler are held at 0.
  - GAMING: prescaler counts 0..TICK_DIV-1 and wraps. On the wrap cycle `time_bcd` increments:
    - s_lo 0–9, s_hi 0–5, m_lo 0–9, m_hi 0–5, each carrying into the next digit;
    - at 59:59 it saturates (no wrap) and the prescaler keeps running.
  - WINNED: `time_bcd` is frozen; the prescaler keeps running (used by the blink option).
  - A state change on the same edge as a tick: the clear in CHOSE_BOARD/GAME_INITIAL wins, and no increment is applied after leaving GAMING.
- **Step converter (FSM IDLE → SHIFT → DONE):**
  - In IDLE, if `step_number` ≠ source register, capture it and go to SHIFT.
  - SHIFT: 8 double-dabble iterations (add 3 to any BCD nibble ≥5, then shift left one bit), one per cycle.
  - DONE: write `step_bcd`, return to IDLE.
  - A `step_number` change during SHIFT/DONE does not abort. It is picked up in the next IDLE cycle, so the last value always converges.
- **Scan:**
  - The scan counter counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→7→0. Digit index i drives `seg_en`[i].
- **Digit map:**
  - 7 = m_hi, 6 = m_lo with dp lit (separator), 5 = s_hi, 4 = s_lo.
  - 3 = blank.
  - 2 = hundreds, 1 = tens, 0 = ones.
  - Hundreds is blanked when 0. Tens is blanked when both hundreds and tens are 0. Ones is always shown.
- **Segment codes:** 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F. Blank = 00. Dp ORs 8'h80.
- **CHOSE_BOARD:** `seg_en`=8'h00 and `seg_out`=8'h00; the scan counter still runs.
- **Other states:** normal scan.

## Timing
- All outputs are registered.
- `seg_en`/`seg_out` reflect the digit index and data with 1 cycle of latency.
- A timer tick updates `time_bcd` on the edge ending prescaler count TICK_DIV-1. First tick: TICK_DIV cycles after entering GAMING from a cleared state.
- Step latency: `step_bcd` holds the new value 10 cycles after a changed `step_number` is first sampled in IDLE (1 capture + 8 shift + 1 write).
- Digit period = SCAN_DIV cycles. Full refresh = 8×SCAN_DIV cycles.

## Configuration
- `SEG_BLINK_ON_WIN_EN` defined:
  - In WINNED, a blink bit toggles on every prescaler wrap.
  - While it is 1, `seg_en` is forced to 8'h00. The blink bit clears on entry to WINNED and on reset.
- `SEG_BLINK_ON_WIN_EN` undefined: WINNED shows a steady display identical to GAMING with a frozen timer. No blink register is built.

## Test plan
1. **Reset clears outputs.** Hold `rst`=0 for 3 cycles with `step_number`=37 → `seg_en`=00, `seg_out`=00, `time_bcd`=0000, `step_bcd`=000. Release → `step_bcd`=037 exactly 10 cycles after the first sampling edge.
2. **Timer counting and blanking.** TICK_DIV=4, SCAN_DIV=2, GAMING for 4×61 cycles → `time_bcd`=16'h0101. Force to 59:58 and run 3 ticks → saturates at 16'h5959. Switch to GAME_INITIAL → 0000 next edge.
3. **Leading-zero suppression.** `step_number`=7 → digits 2 and 1 show 00, digit 0 shows 07. `step_number`=105 → 06/3F/6D. `step_number`=255 → `step_bcd`=12'h255.
4. **Scan sequence and digit map.** Over 16 cycles `seg_en` walks 01,02,…,80 with a 2-cycle dwell. Digit 6 carries dp (`seg_out` bit7=1), digit 3 is 00, and CHOSE_BOARD gives `seg_en`=00 throughout.
5. **Mid-conversion change and simultaneous events.** `step_number` goes 3 → 4 on cycle 2 of SHIFT → `step_bcd` shows 003, then 004 by cycle 20. A tick coinciding with GAMING→WINNED → no increment; `time_bcd` stays frozen.
6. **Blink option.** With `SEG_BLINK_ON_WIN_EN` and TICK_DIV=4, in WINNED `seg_en` is zero for 4 cycles and active for 4 cycles, alternating. Without the macro, `seg_en` is never all-zero in WINNED.
